multicycle_controller: RTL and testbench

- Multicycle successor to the combinational datapath controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM states and latches the opcode and the C/Z flags.
- Resolves conditional branches on the latched flags and drives PC source select, including the JSB/RET return-address stack.
- Owns the stack pointer and raises a sticky fault on stack overflow/underflow. Sits between the instruction register and the datapath muxes, ALU, register file and data memory.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_ret_stack_ptr.sv | 32 +++
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, opcode field encodings and decode helpers for the multicycle controller.
package ctrl_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, FAULT} state_e;

    typedef enum logic [1:0] {
        PC_PLUS1  = 2'd0,
        PC_OFFSET = 2'd1,
        PC_CONST  = 2'd2,
        PC_STACK  = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        ALU_REG2  = 2'd0,
        ALU_CONST = 2'd1,
        ALU_SHIFT = 2'd2
    } alu_src_e;

    typedef enum logic [3:0] {
        K_REG, K_IMM, K_MEM, K_CJMP, K_SHIFT, K_JMP, K_JSB, K_RET, K_NOP
    } op_class_e;

    localparam logic [1:0] CLS_REG   = 2'b00;
    localparam logic [1:0] CLS_IMM   = 2'b01;
    localparam logic [2:0] CLS_MEM   = 3'b100;
    localparam logic [2:0] CLS_CJMP  = 3'b101;
    localparam logic [2:0] CLS_SHIFT = 3'b110;
    localparam logic [4:0] CLS_JMP   = 5'b11100;
    localparam logic [4:0] CLS_JSB   = 5'b11101;
    localparam logic [5:0] OP_RET    = 6'b111100;

    localparam logic [1:0] FN_STM = 2'b00;
    localparam logic [1:0] FN_LDM = 2'b01;

    localparam logic [1:0] FN_BZ  = 2'b00;
    localparam logic [1:0] FN_BNZ = 2'b01;
    localparam logic [1:0] FN_BC  = 2'b10;

    localparam logic [3:0] ADD_FN = 4'b0000;

    function automatic op_class_e classify(input logic [5:0] op);
        if (op[5:4] == CLS_REG)        return K_REG;
        else if (op[5:4] == CLS_IMM)   return K_IMM;
        else if (op[5:3] == CLS_MEM)   return K_MEM;
        else if (op[5:3] == CLS_CJMP)  return K_CJMP;
        else if (op[5:3] == CLS_SHIFT) return K_SHIFT;
        else if (op[5:1] == CLS_JMP)   return K_JMP;
        else if (op[5:1] == CLS_JSB)   return K_JSB;
        else if (op == OP_RET)         return K_RET;
        else                           return K_NOP;
    endfunction

    // BNC is the only remaining encoding, so it takes the default arm.
    function automatic logic cond_taken(input logic [1:0] fn, input logic c, input logic z);
        case (fn)
            FN_BZ:   return z;
            FN_BNZ:  return !z;
            FN_BC:   return c;
            default: return !c;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_ret_stack_ptr.sv
// Return-address stack occupancy counter; the controller guards push/pop with full/empty.
module ctrl_ret_stack_ptr #(
    parameter int DEPTH = 8,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    output logic [SP_W-1:0] sp_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [SP_W-1:0] sp_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    assign sp_o    = sp_q;
    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM sequencer with latched flags, branch resolution
// and a guarded return-address stack pointer.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic            c_in,
    input  logic            z_in,
    input  logic            mem_ready,
    output logic            ir_load,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic [3:0]      alu_op,
    output logic [1:0]      alu_src,
    output logic            sel_cin_alu,
    output logic            rf_write_en,
    output logic            rf_write_src,
    output logic            rf_read_reg2_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            push_stack,
    output logic            pop_stack,
    output logic [SP_W-1:0] sp,
    output logic            fault
);

    state_e     state_q, state_d;
    logic [5:0] op_q;
    logic       c_q, z_q;
    logic       flag_we;
    logic       stack_full, stack_empty;
    op_class_e  op_class;
    logic [1:0] fn;

    assign op_class = classify(op_q);
    assign fn       = op_q[2:1];

    ctrl_ret_stack_ptr #(
        .DEPTH (STACK_DEPTH),
        .SP_W  (SP_W)
    ) u_sp (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_stack),
        .pop_i   (pop_stack),
        .sp_o    (sp),
        .full_o  (stack_full),
        .empty_o (stack_empty)
    );

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        flag_we          = 1'b0;
        ir_load          = 1'b0;
        pc_write         = 1'b0;
        pc_src           = PC_PLUS1;
        alu_op           = ADD_FN;
        alu_src          = ALU_REG2;
        sel_cin_alu      = 1'b0;
        rf_write_en      = 1'b0;
        rf_write_src     = 1'b0;
        rf_read_reg2_src = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        push_stack       = 1'b0;
        pop_stack        = 1'b0;

        // Strobes are gated by rst so an in-flight access drops the moment reset asserts.
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
                DECODE: state_d = EXEC;
                EXEC: begin
                    state_d = FETCH;
                    case (op_class)
                        K_REG, K_IMM: begin
                            alu_op      = {1'b0, op_q[3:1]};
                            alu_src     = (op_class == K_IMM) ? ALU_CONST : ALU_REG2;
                            sel_cin_alu = 1'b1;
                            rf_write_en = 1'b1;
                            flag_we     = 1'b1;
                            pc_write    = 1'b1;
                        end
                        K_SHIFT: begin
                            alu_op      = {2'b11, op_q[2:1]};
                            alu_src     = ALU_SHIFT;
                            sel_cin_alu = 1'b1;
                            rf_write_en = 1'b1;
                            flag_we     = 1'b1;
                            pc_write    = 1'b1;
                        end
                        K_MEM: begin
                            alu_src = ALU_CONST;
                            state_d = MEM;
                        end
                        K_CJMP: begin
                            pc_write = 1'b1;
                            pc_src   = cond_taken(fn, c_q, z_q) ? PC_OFFSET : PC_PLUS1;
                        end
                        K_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_CONST;
                        end
                        K_JSB: begin
                            if (stack_full) begin
                                state_d = FAULT;
                            end else begin
                                push_stack = 1'b1;
                                pc_write   = 1'b1;
                                pc_src     = PC_CONST;
                            end
                        end
                        K_RET: begin
                            if (stack_empty) begin
                                state_d = FAULT;
                            end else begin
                                pop_stack = 1'b1;
                                pc_write  = 1'b1;
                                pc_src    = PC_STACK;
                            end
                        end
                        default: pc_write = 1'b1;
                    endcase
                end
                MEM: begin
                    alu_src = ALU_CONST;
                    if (fn == FN_STM) begin
                        mem_write        = 1'b1;
                        rf_read_reg2_src = 1'b1;
                    end else if (fn == FN_LDM) begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            rf_write_en  = 1'b1;
                            rf_write_src = 1'b1;
                        end
                    end
                    // MEM-class NOP encodings retire on the first MEM cycle.
                    if (mem_ready || (fn != FN_STM && fn != FN_LDM)) begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end
                end
                default: state_d = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) op_q <= opcode;
            if (flag_we) begin
                c_q <= c_in;
                z_q <= z_in;
            end
        end
    end

    assign fault = (state_q == FAULT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a two-entry return stack.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       c_in, z_in, mem_ready;
    logic       ir_load, pc_write, sel_cin_alu, rf_write_en, rf_write_src, rf_read_reg2_src;
    logic       mem_read, mem_write, push_stack, pop_stack, fault;
    logic [1:0] pc_src, alu_src;
    logic [3:0] alu_op;
    logic [1:0] sp;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller #(.STACK_DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .opcode           (opcode),
        .c_in             (c_in),
        .z_in             (z_in),
        .mem_ready        (mem_ready),
        .ir_load          (ir_load),
        .pc_write         (pc_write),
        .pc_src           (pc_src),
        .alu_op           (alu_op),
        .alu_src          (alu_src),
        .sel_cin_alu      (sel_cin_alu),
        .rf_write_en      (rf_write_en),
        .rf_write_src     (rf_write_src),
        .rf_read_reg2_src (rf_read_reg2_src),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .push_stack       (push_stack),
        .pop_stack        (pop_stack),
        .sp               (sp),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: present op, check ir_load, then advance to EXEC.
    task automatic issue(input logic [5:0] op);
        opcode = op;
        #1;
        check("fetch_ir_load", ir_load, 1'b1);
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [6:0] strobes();
        return {ir_load, pc_write, rf_write_en, mem_read, mem_write, push_stack, pop_stack};
    endfunction

    int rd_cycles;

    initial begin
        rst = 1'b1; opcode = '0; c_in = 1'b0; z_in = 1'b0; mem_ready = 1'b0;
        step();
        step();
        check("rst_strobes", strobes(), 7'd0);
        check("rst_pc_src", pc_src, 2'd0);
        check("rst_alu_op", alu_op, 4'd0);
        check("rst_alu_src", alu_src, 2'd0);
        check("rst_sp", sp, 2'd0);
        check("rst_fault", fault, 1'b0);
        rst = 1'b0;
        #1;

        // REG op latches carry
        c_in = 1'b1; z_in = 1'b0;
        issue(6'b000010);
        check("reg_rf_we", rf_write_en, 1'b1);
        check("reg_alu_op", alu_op, 4'b0001);
        check("reg_alu_src", alu_src, 2'd0);
        check("reg_cin", sel_cin_alu, 1'b1);
        check("reg_pc", {pc_write, pc_src}, {1'b1, 2'd0});
        step();
        check("reg_c_q", dut.c_q, 1'b1);
        check("reg_z_q", dut.z_q, 1'b0);

        // LDM with three wait cycles
        issue(6'b100010);
        check("ldm_exec_alu", {alu_op, alu_src}, {4'd0, 2'd1});
        check("ldm_exec_rd", mem_read, 1'b0);
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_read) rd_cycles++;
            check("ldm_wait_done", {rf_write_en, pc_write}, 2'b00);
        end
        step();
        mem_ready = 1'b1;
        #1;
        if (mem_read) rd_cycles++;
        check("ldm_read_cycles", rd_cycles, 4);
        check("ldm_ready", {rf_write_en, rf_write_src, pc_write, pc_src}, {3'b111, 2'd0});
        step();
        mem_ready = 1'b0;
        #1;
        check("ldm_back_fetch", {ir_load, mem_read}, 2'b10);

        // STM, zero wait
        mem_ready = 1'b1;
        issue(6'b100000);
        check("stm_exec_wr", {mem_write, pc_write}, 2'b00);
        step();
        check("stm_mem", {mem_write, rf_read_reg2_src, rf_write_en, pc_write}, 4'b1101);
        step();
        mem_ready = 1'b0;
        #1;
        check("stm_done", {ir_load, mem_write}, 2'b10);

        // IMM latches z=1, c=0; branch cycles see flipped inputs that must not latch
        c_in = 1'b0; z_in = 1'b1;
        issue(6'b010100);
        check("imm_op_src", {alu_op, alu_src}, {4'b0010, 2'd1});
        step();
        c_in = 1'b1; z_in = 1'b0;
        issue(6'b101000);
        check("bz_taken", {pc_write, pc_src}, {1'b1, 2'd1});
        step();
        issue(6'b101010);
        check("bnz_not", {pc_write, pc_src}, {1'b1, 2'd0});
        step();
        issue(6'b101100);
        check("bc_not", {pc_write, pc_src}, {1'b1, 2'd0});
        step();
        issue(6'b101110);
        check("bnc_taken", pc_src, 2'd1);
        step();

        // SHIFT
        issue(6'b110110);
        check("shift_op_src", {alu_op, alu_src, rf_write_en}, {4'b1111, 2'd2, 1'b1});
        step();
        check("shift_c_q", dut.c_q, 1'b1);

        // JSB overflow at depth 2
        for (int i = 1; i <= 2; i++) begin
            issue(6'b111010);
            check("jsb_push", {push_stack, pc_write, pc_src}, {2'b11, 2'd2});
            step();
            check("jsb_sp", sp, i[1:0]);
        end
        issue(6'b111010);
        check("jsb_full_nopush", {push_stack, pc_write}, 2'b00);
        step();
        check("jsb_fault", fault, 1'b1);
        check("jsb_sp_held", sp, 2'd2);
        opcode = 6'b000010; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fault_quiet", {strobes(), fault}, {7'd0, 1'b1});
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("fault_async_clear", {fault, sp}, 3'b000);
        step();
        rst = 1'b0;
        #1;

        // RET underflow
        issue(6'b111100);
        check("ret_empty_nopop", {pop_stack, pc_write}, 2'b00);
        step();
        check("ret_fault", fault, 1'b1);
        do_reset();

        // JSB then RET
        issue(6'b111010);
        step();
        check("jsbret_sp1", sp, 2'd1);
        issue(6'b111100);
        check("ret_pop", {pop_stack, pc_write, pc_src}, {2'b11, 2'd3});
        step();
        check("ret_sp0", {sp, fault}, 3'b000);

        // Async reset in the middle of an STM wait
        c_in = 1'b1; z_in = 1'b1;
        issue(6'b000000);
        step();
        issue(6'b111010);
        step();
        issue(6'b100000);
        step();
        step();
        check("stm_wait_wr", mem_write, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_drop_wr", mem_write, 1'b0);
        check("rst_state", dut.state_q, 32'd0);
        check("rst_sp_flags", {sp, dut.c_q, dut.z_q}, 4'b0000);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_fetch", ir_load, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
